// File: rtl/beat_seq.sv
// Beat (W-state) sequencer feeding the hardwired controller: one-hot W1/W2/W3,
// run/halt control from the QD start button, single-step, completed-cycle counter.
module beat_seq #(
  parameter int CNT_W = 16
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             STEP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  output logic             W1,
  output logic             W2,
  output logic             W3,
  output logic             RUN,
  output logic             EOC,
  output logic [CNT_W-1:0] CYC
);

  // One-hot encoding so the state register bits are the beat outputs directly.
  typedef enum logic [2:0] {
    BEAT_W1 = 3'b001,
    BEAT_W2 = 3'b010,
    BEAT_W3 = 3'b100
  } beat_t;

  beat_t beat, beat_nxt;
  logic  q1, q2, q3;
  logic  start_edge;
  logic  cyc_end;
  logic  run_nxt;

  assign start_edge = q2 & ~q3;

  always_comb begin
    beat_nxt = beat;
    cyc_end  = 1'b0;
    if (RUN) begin
      case (beat)
        BEAT_W1: begin
          if (SHORT) cyc_end  = 1'b1;
          else       beat_nxt = BEAT_W2;
        end
        BEAT_W2: begin
          if (LONG) begin
            beat_nxt = BEAT_W3;
          end else begin
            beat_nxt = BEAT_W1;
            cyc_end  = 1'b1;
          end
        end
        BEAT_W3: begin
          beat_nxt = BEAT_W1;
          cyc_end  = 1'b1;
        end
        default: beat_nxt = BEAT_W1;
      endcase
    end
  end

  // While running, a start edge is ignored and STOP dominates it.
  always_comb begin
    run_nxt = RUN;
    if (RUN) run_nxt = ~(STOP | (cyc_end & STEP));
    else     run_nxt = start_edge;
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      beat <= BEAT_W1;
      q1   <= 1'b0;
      q2   <= 1'b0;
      q3   <= 1'b0;
      RUN  <= 1'b0;
      EOC  <= 1'b0;
      CYC  <= '0;
    end else begin
      beat <= beat_nxt;
      q1   <= QD;
      q2   <= q1;
      q3   <= q2;
      RUN  <= run_nxt;
      EOC  <= cyc_end;
      if (cyc_end) CYC <= CYC + CNT_W'(1);
    end
  end

  assign W1 = beat[0];
  assign W2 = beat[1];
  assign W3 = beat[2];

endmodule

// File: tb/tb_beat_seq.sv
// Randomized bench for beat_seq: a behavioural beat/run/cycle model predicts outputs
// after every falling T3 edge; two instances cover the 16-bit and 4-bit (wrapping) counter.
module tb_beat_seq;

  localparam int EW = 21;  // {beats[2:0], run, eoc, cyc[15:0]}

  logic        T3, CLR, QD, STEP, SHORT, LONG, STOP;
  logic        w1_a, w2_a, w3_a, run_a, eoc_a;
  logic [15:0] cyc_a;
  logic        w1_b, w2_b, w3_b, run_b, eoc_b;
  logic [3:0]  cyc_b;

  beat_seq #(.CNT_W(16)) dut_a (
    .T3(T3), .CLR(CLR), .QD(QD), .STEP(STEP), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W1(w1_a), .W2(w2_a), .W3(w3_a), .RUN(run_a), .EOC(eoc_a), .CYC(cyc_a)
  );

  beat_seq #(.CNT_W(4)) dut_b (
    .T3(T3), .CLR(CLR), .QD(QD), .STEP(STEP), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W1(w1_b), .W2(w2_b), .W3(w3_b), .RUN(run_b), .EOC(eoc_b), .CYC(cyc_b)
  );

  // clock / reset block
  initial begin
    T3 = 1'b1;
    forever #5 T3 = ~T3;
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: beat number 1..3, run flag, total cycles, QD sample history
  int          m_beat;
  bit          m_run, m_eoc;
  int unsigned m_cyc;
  bit          qd_hist[$];

  task automatic model_reset();
    m_beat = 1;
    m_run  = 0;
    m_eoc  = 0;
    m_cyc  = 0;
    qd_hist = {1'b0, 1'b0, 1'b0};  // newest first: q1, q2, q3
  endtask

  task automatic model_edge();
    bit start, ended;
    start = qd_hist[1] && !qd_hist[2];
    ended = 0;
    if (m_run) begin
      if (m_beat == 1) begin
        if (SHORT) ended = 1; else m_beat = 2;
      end else if (m_beat == 2) begin
        if (LONG) m_beat = 3; else begin m_beat = 1; ended = 1; end
      end else begin
        m_beat = 1;
        ended  = 1;
      end
      if (STOP || (ended && STEP)) m_run = 0;
    end else if (start) begin
      m_run = 1;
    end
    m_eoc = ended;
    if (ended) m_cyc++;
    qd_hist.push_front(QD);
    void'(qd_hist.pop_back());
  endtask

  function automatic logic [EW-1:0] model_pack();
    logic [2:0]  oh;
    logic [15:0] c;
    oh = 3'(1 << (m_beat - 1));
    c  = m_cyc[15:0];
    return {oh, m_run, m_eoc, c};
  endfunction

  task automatic compare(input logic [EW-1:0] e);
    check_eq("beats_a", {w3_a, w2_a, w1_a}, e[20:18]);
    check_eq("run_a",   run_a,  e[17]);
    check_eq("eoc_a",   eoc_a,  e[16]);
    check_eq("cyc_a",   cyc_a,  e[15:0]);
    check_eq("beats_b", {w3_b, w2_b, w1_b}, e[20:18]);
    check_eq("run_b",   run_b,  e[17]);
    check_eq("eoc_b",   eoc_b,  e[16]);
    check_eq("cyc_b",   cyc_b,  e[3:0]);
  endtask

  // driver tasks
  task automatic tick();
    @(negedge T3);
    model_edge();
    exp_q.push_back(model_pack());
    @(posedge T3);
    #1;
    if (exp_q.size() == 0) check_eq("queue_empty", 32'd0, 32'd1);
    else compare(exp_q.pop_front());
  endtask

  // Called mid-period (just after a posedge); reset must act without a T3 edge.
  task automatic do_reset();
    CLR = 1'b0;
    #1;
    model_reset();
    compare(model_pack());
    #1;
    CLR = 1'b1;
  endtask

  initial begin
    CLR = 1'b1; QD = 1'b0; STEP = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    model_reset();
    @(posedge T3);
    #1;

    // reset then idle
    do_reset();
    repeat (10) tick();

    // start latency and normal 2-beat cycles
    QD = 1'b1;
    repeat (12) tick();

    // SHORT holds W1; LONG stretches to W3
    SHORT = 1'b1;
    repeat (5) tick();
    SHORT = 1'b0; LONG = 1'b1;
    repeat (9) tick();
    LONG = 1'b0;

    // STOP with SHORT, stay halted, then resume via fresh press
    for (int i = 0; i < 4 && m_beat != 1; i++) tick();
    SHORT = 1'b1; STOP = 1'b1;
    tick();
    STOP = 1'b0; SHORT = 1'b0;
    repeat (3) tick();
    QD = 1'b0;
    repeat (3) tick();
    QD = 1'b1;
    repeat (6) tick();
    QD = 1'b0;

    // single-step: one cycle per press
    STEP = 1'b1;
    repeat (3) tick();
    do_reset();
    QD = 1'b1;
    repeat (8) tick();
    check_eq("step_cyc1", cyc_a, 32'd1);
    QD = 1'b0;
    repeat (3) tick();
    QD = 1'b1;
    repeat (8) tick();
    check_eq("step_cyc2", cyc_a, 32'd2);
    QD = 1'b0;
    STEP = 1'b0;

    // 4-bit counter wrap after 17 cycles, then async reset while in W2
    do_reset();
    QD = 1'b1;
    for (int i = 0; i < 200 && m_cyc != 17; i++) tick();
    check_eq("wrap17_b", cyc_b, 32'd1);
    check_eq("wrap17_a", cyc_a, 32'd17);
    for (int i = 0; i < 6 && m_beat != 2; i++) tick();
    check_eq("pre_clr_w2", w2_a, 32'd1);
    do_reset();
    QD = 1'b0;
    repeat (3) tick();

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) QD = ~QD;
      STEP  = ($urandom_range(0, 5) == 0);
      SHORT = ($urandom_range(0, 3) == 0);
      LONG  = ($urandom_range(0, 1) == 0);
      STOP  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_seq.md
Name: beat_seq

Overview:
- Beat (W-state) sequencer that sits directly upstream of the hardwired controller.
- Generates the one-hot beat signals W1/W2/W3 that the controller decodes.
- Consumes the controller's SHORT, LONG and STOP outputs to shorten, lengthen or halt the machine cycle.
- Owns run/halt control from the front-panel start button QD, single-step mode, and a completed-instruction-cycle counter for debug display.

Parameters:
CNT_W, 16, width of the completed-cycle counter CYC (wraps modulo 2^CNT_W).

Ports:
T3  input  1  beat clock; all state updates on the falling edge.
CLR  input  1  asynchronous active-low reset.
QD  input  1  start push-button, asynchronous to T3, level.
STEP  input  1  single-step mode; 1 = halt after every completed machine cycle.
SHORT  input  1  from controller: current cycle ends after W1.
LONG  input  1  from controller: cycle extends to W3.
STOP  input  1  from controller: halt after the current beat.
W1  output  1  beat 1 (one-hot with W2, W3).
W2  output  1  beat 2.
W3  output  1  beat 3.
RUN  output  1  1 = beats advancing; 0 = halted, waiting for QD.
EOC  output  1  registered one-period pulse: a machine cycle completed at the last edge.
CYC  output  CNT_W  count of completed machine cycles.

Behaviour:
- Reset (CLR=0, asynchronous, regardless of T3):
  - W1=1, W2=0, W3=0, RUN=0, EOC=0, CYC=0.
  - QD synchronizer registers q1, q2, q3 = 0.
  - Reset mid-cycle aborts the cycle; no EOC, no CYC increment.
- Clocking:
  - All registers update on negedge T3 only.
  - Outputs are registers; no combinational path from inputs to outputs.
- QD synchronizer and start:
  - q1<=QD, q2<=q1, q3<=q2; start edge = q2 & ~q3.
  - QD first sampled high at edge k -> RUN=1 after edge k+2.
  - Start edge with RUN=1 is ignored.
  - QD held high produces exactly one start edge.
  - QD bounce shorter than one T3 period may or may not be seen; no debouncing is required.
- Beat state machine (one-hot W1/W2/W3); advances only at edges where registered RUN=1:
  - W1: SHORT=1 -> W1, end of cycle; else -> W2.
  - W2: LONG=1 -> W3; else -> W1, end of cycle.
  - W3: -> W1, end of cycle (SHORT/LONG ignored).
  - SHORT and LONG both 1 in W1: SHORT wins.
  - LONG in W1 is ignored; SHORT in W2 is ignored.
  - RUN=0: W1..W3 hold; SHORT, LONG and STOP are ignored.
- End of cycle (EOC event, at an advancing edge):
  - EOC<=1 for one period; otherwise EOC<=0.
  - CYC<=CYC+1; 2^CNT_W-1 wraps to 0.
- Halt conditions, at any advancing edge:
  - STOP=1 -> RUN<=0.
  - End of cycle with STEP=1 -> RUN<=0.
  - The beat still advances at that edge, so the machine halts in the next beat. A STOP in W1 with SHORT=0 halts in W2.
- Simultaneous events:
  - Start edge while RUN=0: RUN<=1; STOP/STEP are not evaluated at that edge because no advance occurs.
  - RUN=1 with STOP=1 and a start edge: RUN<=0 (stop wins).
- Invariant: exactly one of W1/W2/W3 is high at all times after reset.

Test Plan:
1. Reset then idle: CLR low, then high, QD=0 for 10 edges -> W1=1, RUN=0, CYC=0, EOC never high.
2. Start latency plus normal cycle: QD high at edge 0, SHORT=LONG=STOP=0 -> RUN=1 after edge 2; beats W2 after edge 3, W1 after edge 4 with EOC=1 and CYC=1; repeating 2-beat cycles.
3. SHORT and LONG: SHORT=1 in every W1 -> W1 held, CYC increments every edge. LONG=1 in W2 -> sequence W1,W2,W3,W1 with CYC+1 per 3 edges.
4. STOP: running, STOP=1 during W1 with SHORT=1 -> after that edge RUN=0, W1=1, CYC+1. Next QD press -> resumes with W1 unchanged.
5. Single-step: STEP=1, QD pressed -> exactly one 2-beat cycle runs, then RUN=0 with W1=1 and CYC=1. A second press gives CYC=2.
6. Wrap and async reset: CNT_W=4, run 17 cycles -> CYC=1. CLR pulsed low while in W2 between edges -> immediately W1=1, RUN=0, CYC=0.
